alu_sched: RTL

//  Round-robin scheduler sharing one registered 32-bit ALU among N_REQ requesters.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_sched_rr_arbiter.sv | 37 +++
 rtl/alu_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler: opcodes, scheduler states, default widths.
package alu_pkg;

   localparam int ALU_DW  = 32;
   localparam int ALU_OPW = 3;

   typedef enum logic [ALU_OPW-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } alu_op_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP,
      CLEAR
   } sched_state_e;

   // True for opcode encodings outside the ALU's defined operation set.
   function automatic logic op_illegal(input logic [ALU_OPW-1:0] op);
      return op > OP_XOR;
   endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping to index 0.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [N-1:0] hi_mask;
   logic [N-1:0] sel;
   logic         found;

   // Requesters above the pointer take priority; otherwise fall back to the lowest index.
   always_comb begin
      // NOTE: every output gets a default before any conditional write so no latch is inferred.
      hi_mask = '0;
      gnt     = '0;
      idx     = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = IW'(i) > ptr;
      end
      sel = (|(req & hi_mask)) ? (req & hi_mask) : req;
      for (int i = 0; i < N; i++) begin
         if (sel[i] && !found) begin
            gnt[i] = 1'b1;
            idx    = IW'(i);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU among N_REQ requesters.
// Optional build macro ALU_SCHED_OPCHK_EN: opcodes 5..7 are rejected locally without using the ALU.
module alu_sched
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = ALU_DW,
   parameter int OPW   = ALU_OPW,
   localparam int IDW  = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*DW-1:0]  req_a,
   input  logic [N_REQ*DW-1:0]  req_b,
   input  logic [N_REQ*OPW-1:0] req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [DW-1:0]        rsp_result,
   output logic                 rsp_error,
   output logic [DW-1:0]        alu_a,
   output logic [DW-1:0]        alu_b,
   output logic [OPW-1:0]       alu_opcode,
   output logic                 alu_rst,
   input  logic [DW-1:0]        alu_result,
   input  logic                 alu_error,
   output logic                 busy
);

   sched_state_e   state_q, state_d;
   logic [IDW-1:0] ptr_q;
   logic [N_REQ-1:0] gnt;
   logic [IDW-1:0] win_idx;
   logic [DW-1:0]  win_a, win_b;
   logic [OPW-1:0] win_op;
   logic           win_rej;
   logic           needs_clear;
   logic           grant;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (win_idx)
   );

   assign win_a  = req_a[int'(win_idx)*DW +: DW];
   assign win_b  = req_b[int'(win_idx)*DW +: DW];
   assign win_op = req_op[int'(win_idx)*OPW +: OPW];
   assign grant  = (state_q == IDLE) && (|req_valid);

`ifdef ALU_SCHED_OPCHK_EN
   logic rej_q;

   assign win_rej     = op_illegal(win_op);
   // Locally rejected ops never touched the ALU, so there is no sticky error to clear.
   assign needs_clear = rsp_error & ~rej_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rej_q <= 1'b0;
      end else if (grant) begin
         rej_q <= win_rej;
      end
   end
`else
   assign win_rej     = 1'b0;
   assign needs_clear = rsp_error;
`endif

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready = gnt;
               state_d   = win_rej ? RESP : ISSUE;
            end
         end
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_d = needs_clear ? CLEAR : IDLE;
            end
         end
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= IDW'(N_REQ - 1);
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_error  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (grant) begin
                  ptr_q  <= win_idx;
                  rsp_id <= win_idx;
                  if (win_rej) begin
                     rsp_result <= '0;
                     rsp_error  <= 1'b1;
                  end else begin
                     alu_a      <= win_a;
                     alu_b      <= win_b;
                     alu_opcode <= win_op;
                  end
               end
            end
            CAPTURE: begin
               rsp_result <= alu_result;
               rsp_error  <= alu_error;
            end
            RESP: begin
               // The ALU recomputes every cycle; park it on a legal op so the sticky
               // error is not re-raised by the stale illegal opcode after the clear.
               if (rsp_ready && needs_clear) begin
                  alu_a      <= '0;
                  alu_b      <= '0;
                  alu_opcode <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign alu_rst   = ~rst_n | (state_q == CLEAR);

endmodule
